fetch_pc_sequencer: RTL
=======================

// Module: fetch_pc_sequencer
// PURPOSE
//  Owns the fetch PC. Each cycle it picks the next PC from: sequential pc+4, the predicted-taken
//  target from the branch predictor, or a recovery address on misprediction.
//  Sits directly upstream of the predictor's consumers; it takes the predictor's prediction and
//  branch_addr and keeps a FIFO of unresolved branches. Branches resolve in order in MEM.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  DEPTH      4              unresolved-branch FIFO entries (power of 2, >=2)
//  CNT_W      16             width of saturating statistic counters
// PORTS
//  clk                    in   1   clock, all state on posedge
//  rst_n                  in   1   asynchronous active-low reset
//  stall                  in   1   hazard stall; hold PC, no FIFO push
//  branch_decode_sig      in   1   decode stage holds a conditional branch (push request)
//  decode_pc              in   32  PC of the instruction in decode
//  prediction             in   1   predictor's taken/not-taken for the decode branch
//  branch_addr            in   32  predicted target (decode_pc + offset) from the predictor
//  branch_mem_sig         in   1   oldest in-flight branch resolves this cycle (pop request)
//  actual_branch_decision in   1   resolved outcome of that branch
//  pc_out                 out  32  current fetch PC
//  flush                  out  1   1-cycle pulse; squash IF/ID/EX wrong-path instructions
//  fifo_full              out  1   FIFO holds DEPTH entries
//  overflow_err           out  1   sticky: push attempted while full
//  underflow_err          out  1   sticky: resolve seen while FIFO empty
//  pred_count             out  CNT_W  resolved branches, saturating
//  mispred_count          out  CNT_W  mispredicted branches, saturating
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_out=RESET_PC. FIFO empty. flush, overflow_err, underflow_err=0.
//   Counters=0. Reset mid-operation discards all in-flight entries.
//  Each FIFO entry holds {pred, target=branch_addr, fallthrough=decode_pc+4}; additions are
//   mod 2^32 and wrap.
//  push = branch_decode_sig & !stall & !mispredict. pop = branch_mem_sig & !empty.
//  mispredict = pop & (head.pred != actual_branch_decision) (combinational).
//  Next-PC priority, registered at posedge:
//   1 mispredict: pc_out <= actual ? head.target : head.fallthrough; flush <= 1.
//     The whole FIFO is cleared; younger entries are wrong-path. A same-cycle push is dropped.
//   2 stall: pc_out holds.
//   3 push & prediction: pc_out <= branch_addr.
//   4 otherwise: pc_out <= pc_out + 4.
//  flush is high exactly one cycle, the same cycle pc_out shows the recovery address.
//   It is 0 in every other cycle.
//  Correct resolution: the head entry is popped, with no redirect and no flush.
//  Simultaneous push and correct pop: both occur and occupancy is unchanged. This is legal
//   when full.
//  Push while full without a same-cycle pop: entry dropped, overflow_err <= 1.
//   pc_out still follows rule 3/4.
//  branch_mem_sig while empty: ignored, underflow_err <= 1, no flush.
//  Counters: pred_count +1 on each pop; mispred_count +1 on each mispredict.
//   Both hold at 2^CNT_W-1.
//  Error flags clear only on reset.
//  fifo_full is combinational from occupancy. Latency from any input to pc_out/flush is 1 cycle.
// TESTING
//  1 Reset with RESET_PC=0x100, then release with no branches -> pc_out 0x100,0x104,0x108.
//    flush stays 0.
//  2 Decode branch at 0x200, prediction=1, branch_addr=0x240 -> next pc_out=0x240.
//    Later resolve actual=1 -> no flush, pred_count=1.
//  3 Same branch resolved actual=0 -> next cycle pc_out=0x204, flush=1 for one cycle.
//    FIFO is empty afterwards and mispred_count=1.
//  4 Not-taken prediction at 0x300 (target 0x380), resolved taken -> pc_out=0x380, flush pulse.
//    A push issued in the same resolve cycle is dropped.
//  5 stall=1 for 3 cycles with branch_decode_sig=1 -> pc_out holds and there is no push.
//    A mispredict resolved during the stall still redirects.
//  6 Fill DEPTH entries, then push again -> fifo_full=1 and overflow_err=1.
//    Then, with the FIFO empty, branch_mem_sig=1 -> underflow_err=1 and no flush.

Source files
------------

// File: rtl/fetch_pc_sequencer_if.sv
// fetch_pc_sequencer_if: decode/MEM branch bus and status between the pipeline and the PC sequencer
interface fetch_pc_sequencer_if #(parameter int CNT_W = 16);
    logic             stall;
    logic             branch_decode_sig;
    logic [31:0]      decode_pc;
    logic             prediction;
    logic [31:0]      branch_addr;
    logic             branch_mem_sig;
    logic             actual_branch_decision;
    logic [31:0]      pc_out;
    logic             flush;
    logic             fifo_full;
    logic             overflow_err;
    logic             underflow_err;
    logic [CNT_W-1:0] pred_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output stall, branch_decode_sig, decode_pc, prediction, branch_addr,
               branch_mem_sig, actual_branch_decision,
        input  pc_out, flush, fifo_full, overflow_err, underflow_err, pred_count, mispred_count
    );

    modport slave (
        input  stall, branch_decode_sig, decode_pc, prediction, branch_addr,
               branch_mem_sig, actual_branch_decision,
        output pc_out, flush, fifo_full, overflow_err, underflow_err, pred_count, mispred_count
    );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: owns the fetch PC and tracks unresolved branches for in-order recovery
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter int          CNT_W    = 16
) (
    input logic clk,
    input logic rst_n,
    fetch_pc_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic             pred_q   [DEPTH];
    logic [31:0]      target_q [DEPTH];
    logic [31:0]      fall_q   [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic [AW:0]      count;
    logic [31:0]      pc;
    logic             flush_q, ovf_q, unf_q;
    logic [CNT_W-1:0] pred_cnt, mispred_cnt;
    logic             empty, full, pop, mispredict, push_req, push;

    // Queue status and the resolve/push decisions for this cycle.
    always_comb begin
        empty      = count == '0;
        full       = count == (AW+1)'(DEPTH);
        pop        = bus.branch_mem_sig & !empty;
        mispredict = pop & (pred_q[rd_ptr] != bus.actual_branch_decision);
        push_req   = bus.branch_decode_sig & !bus.stall & !mispredict;
        push       = push_req & (!full | pop);
    end

    // Entry payload; validity comes from occupancy, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            pred_q[wr_ptr]   <= bus.prediction;
            target_q[wr_ptr] <= bus.branch_addr;
            fall_q[wr_ptr]   <= bus.decode_pc + 32'd4;
        end
    end

    // Pointers, occupancy, sticky error flags and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            pred_cnt    <= '0;
            mispred_cnt <= '0;
        end else begin
            if (mispredict) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop) rd_ptr <= rd_ptr + AW'(1);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
            if (push_req & full & !pop) ovf_q <= 1'b1;
            if (bus.branch_mem_sig & empty) unf_q <= 1'b1;
            if (pop & ~&pred_cnt) pred_cnt <= pred_cnt + CNT_W'(1);
            if (mispredict & ~&mispred_cnt) mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

    // Next PC: recovery beats stall, stall beats a taken prediction, else sequential.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC;
            flush_q <= 1'b0;
        end else begin
            pc <= mispredict ? (bus.actual_branch_decision ? target_q[rd_ptr] : fall_q[rd_ptr])
                : bus.stall ? pc
                : (push_req & bus.prediction) ? bus.branch_addr
                : pc + 32'd4;
            flush_q <= mispredict;
        end
    end

    assign bus.pc_out        = pc;
    assign bus.flush         = flush_q;
    assign bus.fifo_full     = full;
    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = unf_q;
    assign bus.pred_count    = pred_cnt;
    assign bus.mispred_count = mispred_cnt;
endmodule
